// File: rtl/teamplayer_n_if.sv
// Pin-side bundle of one controller port served by the multi-pad tap.
//   CE          : clock enable for the whole engine
//   TH, TR      : console-driven handshake levels (already in the CLK domain)
//   PAD_BTN     : 12 bits per pad {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}
//   PAD_PRESENT : per-pad connected flag
//   PAD_6BTN    : per-pad 6-button flag
//   D_OUT       : nibble on D3..D0
//   TL_OUT      : ack line
//   BUSY        : sequence in progress
interface teamplayer_n_if #(parameter int NPADS = 4);
  logic                   CE;
  logic                   TH;
  logic                   TR;
  logic [12*NPADS-1:0]    PAD_BTN;
  logic [NPADS-1:0]       PAD_PRESENT;
  logic [NPADS-1:0]       PAD_6BTN;
  logic [3:0]             D_OUT;
  logic                   TL_OUT;
  logic                   BUSY;

  modport slave  (input  CE, TH, TR, PAD_BTN, PAD_PRESENT, PAD_6BTN,
                  output D_OUT, TL_OUT, BUSY);
  modport master (output CE, TH, TR, PAD_BTN, PAD_PRESENT, PAD_6BTN,
                  input  D_OUT, TL_OUT, BUSY);
endinterface

// File: rtl/teamplayer_n.sv
// Multi-pad tap engine: serves NPADS sub-pads over one port using the
// TH/TR/TL nibble handshake, with programmable ack delay, per-sequence
// button snapshot and a stall timeout.
//   CLK   : system clock
//   RESET : asynchronous, active-high
//   tp    : teamplayer_n_if.slave (CE, TH, TR, PAD_* in; D_OUT, TL_OUT, BUSY out)

// Per-pad nibble decode from the snapshotted button word.
module teamplayer_n_lane (
  input  logic [11:0] btn,
  input  logic        present,
  input  logic        six,
  output logic [3:0]  id,
  output logic [3:0]  n0,
  output logic [3:0]  n1,
  output logic [3:0]  n2
);
  assign id = !present ? 4'hF : (six ? 4'h1 : 4'h0);
  assign n0 = ~btn[3:0];                                // RIGHT,LEFT,DOWN,UP
  assign n1 = ~{btn[7], btn[4], btn[6], btn[5]};        // START,A,C,B
  assign n2 = ~{btn[8], btn[9], btn[10], btn[11]};      // MODE,X,Y,Z
endmodule

module teamplayer_n #(
  parameter int NPADS     = 4,
  parameter int ACK_DELAY = 4,
  parameter int TIMEOUT   = 2048
) (
  input  logic CLK,
  input  logic RESET,
  teamplayer_n_if.slave tp
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_n;
  logic                   th_q;
  logic                   tl, tl_n;
  logic [3:0]             d, d_n;
  logic [5:0]             idx, idx_n, idx_inc;
  logic [3:0]             ack_cnt, ack_n;
  logic [TW-1:0]          to_cnt, to_n;
  logic                   snap_load, ack_done;
  logic                   th_fall, th_rise;

  logic [NPADS-1:0][11:0] snap_btn;
  logic [NPADS-1:0]       snap_present, snap_six;
  logic [NPADS-1:0][3:0]  pid, pn0, pn1, pn2;

  // Full 64-entry nibble map indexed directly by idx; unused slots stay F,
  // which gives the post-sequence F fill for free.
  logic [63:0][3:0]       nib;
  logic [5:0]             ptr;

  for (genvar g = 0; g < NPADS; g++) begin : g_lane
    teamplayer_n_lane u_lane (
      .btn     (snap_btn[g]),
      .present (snap_present[g]),
      .six     (snap_six[g]),
      .id      (pid[g]),
      .n0      (pn0[g]),
      .n1      (pn1[g]),
      .n2      (pn2[g])
    );
  end

  // Pack data nibbles back to back; absent pads contribute none.
  always_comb begin
    nib    = '1;
    nib[0] = 4'h3;
    nib[2] = 4'h0;
    nib[3] = 4'h0;
    for (int p = 0; p < NPADS; p++) nib[6'(4 + p)] = pid[p];
    ptr = 6'(4 + NPADS);
    for (int p = 0; p < NPADS; p++) begin
      if (snap_present[p]) begin
        nib[ptr]        = pn0[p];
        nib[ptr + 6'd1] = pn1[p];
        ptr             = ptr + 6'd2;
        if (snap_six[p]) begin
          nib[ptr] = pn2[p];
          ptr      = ptr + 6'd1;
        end
      end
    end
  end

  assign th_fall = th_q & ~tp.TH;
  assign th_rise = ~th_q & tp.TH;
  assign idx_inc = (idx == 6'd63) ? idx : idx + 6'd1;

  always_comb begin
    state_n   = state;
    tl_n      = tl;
    d_n       = d;
    idx_n     = idx;
    ack_n     = ack_cnt;
    to_n      = to_cnt;
    snap_load = 1'b0;
    ack_done  = 1'b0;
    case (state)
      IDLE: begin
        d_n   = 4'h3;
        tl_n  = 1'b1;
        idx_n = '0;
        ack_n = '0;
        to_n  = '0;
        if (th_fall) begin
          state_n   = ACTIVE;
          snap_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (th_rise) begin
          // Abort wins over any pending ack or timeout.
          state_n = IDLE;
          d_n     = 4'h3;
          tl_n    = 1'b1;
          idx_n   = '0;
          ack_n   = '0;
          to_n    = '0;
        end else begin
          // Level-based ack: counter runs while TR differs from TL and only
          // clears when they agree again, so extra TR toggles don't restart it.
          if (tp.TR != tl) begin
            if (ack_cnt == 4'(ACK_DELAY - 1)) ack_done = 1'b1;
            else                              ack_n    = ack_cnt + 4'd1;
          end else begin
            ack_n = '0;
          end
          if (ack_done) begin
            tl_n  = tp.TR;
            idx_n = idx_inc;
            d_n   = nib[idx_inc];
            ack_n = '0;
            to_n  = '0;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            // Stalled console: restart the sequence with fresh pad state.
            snap_load = 1'b1;
            idx_n     = '0;
            d_n       = 4'h3;
            tl_n      = tp.TR;
            ack_n     = '0;
            to_n      = '0;
          end else begin
            to_n = to_cnt + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      th_q         <= 1'b1;
      tl           <= 1'b1;
      d            <= 4'h3;
      idx          <= '0;
      ack_cnt      <= '0;
      to_cnt       <= '0;
      snap_btn     <= '0;
      snap_present <= '0;
      snap_six     <= '0;
    end else if (tp.CE) begin
      state   <= state_n;
      th_q    <= tp.TH;
      tl      <= tl_n;
      d       <= d_n;
      idx     <= idx_n;
      ack_cnt <= ack_n;
      to_cnt  <= to_n;
      if (snap_load) begin
        snap_btn     <= tp.PAD_BTN;
        snap_present <= tp.PAD_PRESENT;
        snap_six     <= tp.PAD_6BTN;
      end
    end
  end

  assign tp.D_OUT  = d;
  assign tp.TL_OUT = tl;
  assign tp.BUSY   = (state == ACTIVE);
endmodule

// File: tb/tb_teamplayer_n.sv
module tb_teamplayer_n;
  localparam int NPADS     = 4;
  localparam int ACK_DELAY = 4;
  localparam int TIMEOUT   = 16;

  logic CLK, RESET;
  teamplayer_n_if #(.NPADS(NPADS)) tp();

  teamplayer_n #(.NPADS(NPADS), .ACK_DELAY(ACK_DELAY), .TIMEOUT(TIMEOUT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .tp    (tp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic [3:0] d;
    logic       tl;
    logic       busy;
    int         tick;   // expected CE tick count, -1 = any
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         fails  = 0;
  int         ce_cnt = 0;
  logic       mon_en = 1'b0;
  logic [5:0] prev;
  logic       half   = 1'b0;

  always @(posedge CLK) if (tp.CE) ce_cnt <= ce_cnt + 1;

  // Monitor: every change of the output tuple consumes one expectation.
  always @(negedge CLK) begin
    if (mon_en) begin
      logic [5:0] cur;
      exp_t e;
      cur = {tp.D_OUT, tp.TL_OUT, tp.BUSY};
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: got d=%h tl=%b busy=%b at tick %0d, required no change",
                   tp.D_OUT, tp.TL_OUT, tp.BUSY, ce_cnt);
        end else begin
          e = q.pop_front();
          if (cur !== {e.d, e.tl, e.busy} || (e.tick >= 0 && e.tick != ce_cnt)) begin
            fails++;
            $display("FAIL %s: got d=%h tl=%b busy=%b tick=%0d, required d=%h tl=%b busy=%b tick=%0d",
                     e.nm, tp.D_OUT, tp.TL_OUT, tp.BUSY, ce_cnt, e.d, e.tl, e.busy, e.tick);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] d, input logic tl,
                      input logic busy, input int tick);
    exp_t e;
    e.nm = nm; e.d = d; e.tl = tl; e.busy = busy; e.tick = tick;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic ce_tick();
    if (half) begin
      tp.CE = 1'b0;
      @(negedge CLK);
    end
    tp.CE = 1'b1;
    @(negedge CLK);
  endtask

  task automatic th_fall(input string nm);
    tp.TR = 1'b1;
    tp.TH = 1'b0;
    push(nm, 4'h3, 1'b1, 1'b1, ce_cnt + 1);
    ce_tick();
  endtask

  task automatic th_rise(input string nm);
    tp.TH = 1'b1;
    push(nm, 4'h3, 1'b1, 1'b0, ce_cnt + 1);
    ce_tick();
  endtask

  task automatic ack(input string nm, input logic [3:0] nd);
    tp.TR = ~tp.TR;
    push(nm, nd, tp.TR, 1'b1, ce_cnt + ACK_DELAY);
    repeat (ACK_DELAY) ce_tick();
  endtask

  task automatic ack_list(input string nm, input logic [3:0] v [], input int n);
    for (int i = 0; i < n; i++) ack($sformatf("%s[%0d]", nm, i + 1), v[i]);
  endtask

  logic [3:0] full_seq [] = '{4'hF,4'h0,4'h0,4'h0,4'h1,4'hF,4'h0,4'hE,
                              4'hB,4'hF,4'hF,4'hE,4'hF,4'hF,4'hF,4'hF};
  logic [3:0] snap2    [] = '{4'hF,4'h0,4'h0,4'h0,4'h1,4'hF,4'h0,4'hD,4'hF};
  logic [3:0] tmo_seq  [] = '{4'hF,4'h0,4'h0,4'h0,4'h1,4'h0,4'h0,4'hB};

  initial begin
    RESET          = 1'b0;
    tp.CE          = 1'b0;
    tp.TH          = 1'b1;
    tp.TR          = 1'b1;
    tp.PAD_BTN     = {12'h000, 12'h000, 12'h800, 12'h011};
    tp.PAD_PRESENT = 4'b1011;
    tp.PAD_6BTN    = 4'b0010;

    // 1. asynchronous reset mid-cycle
    #3 RESET = 1'b1;
    #1;
    chk("rst_d",    tp.D_OUT, 4'h3);
    chk("rst_tl",   {3'b0, tp.TL_OUT}, 4'h1);
    chk("rst_busy", {3'b0, tp.BUSY}, 4'h0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    prev   = {tp.D_OUT, tp.TL_OUT, tp.BUSY};
    mon_en = 1'b1;
    @(negedge CLK);

    // 2. full sequence, 16 acks
    th_fall("seq_start");
    ack_list("seq", full_seq, 16);
    th_rise("seq_end");

    // 3. ack timing, glitch, half-rate CE
    th_fall("tim_start");
    ack("tim_full", 4'hF);
    tp.TR = ~tp.TR;
    repeat (2) ce_tick();
    tp.TR = ~tp.TR;
    repeat (3) ce_tick();
    half = 1'b1;
    ack("tim_half", 4'h0);
    half = 1'b0;
    th_rise("tim_end");

    // 4. abort at idx 7 with ack expiring on the same tick as TH rise
    th_fall("abt_start");
    ack_list("abt", full_seq, 7);
    tp.TR = ~tp.TR;
    repeat (ACK_DELAY - 1) ce_tick();
    th_rise("abt_rise");
    th_fall("abt_restart");
    ack("abt_r1", 4'hF);
    ack("abt_r2", 4'h0);
    th_rise("abt_end");

    // 5. snapshot isolation
    th_fall("snp_start");
    ack_list("snp", full_seq, 5);
    tp.PAD_BTN = {12'h000, 12'h000, 12'h800, 12'h002};
    ack("snp6", 4'hF);
    ack("snp7", 4'h0);
    ack("snp8_old", 4'hE);
    th_rise("snp_end");
    th_fall("snp2_start");
    ack_list("snp2", snap2, 9);
    th_rise("snp2_end");

    // 6. timeout re-snapshot, then ack colliding with timeout
    th_fall("tmo_start");
    ack("tmo_a1", 4'hF);
    tp.PAD_BTN     = {12'h000, 12'h000, 12'h800, 12'h004};
    tp.PAD_PRESENT = 4'b1111;
    push("tmo_fire", 4'h3, tp.TR, 1'b1, ce_cnt + TIMEOUT);
    repeat (TIMEOUT) ce_tick();
    ack_list("tmo", tmo_seq, 8);
    repeat (TIMEOUT - ACK_DELAY) ce_tick();
    ack("tmo_ack_wins", 4'hF);
    push("tmo_fire2", 4'h3, tp.TR, 1'b1, ce_cnt + TIMEOUT);
    repeat (TIMEOUT) ce_tick();
    th_rise("tmo_end");

    // 7. reset mid-sequence
    th_fall("mrst_start");
    ack("mrst_a1", 4'hF);
    ack("mrst_a2", 4'h0);
    push("mrst_mon", 4'h3, 1'b1, 1'b0, -1);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("mrst_d",    tp.D_OUT, 4'h3);
    chk("mrst_tl",   {3'b0, tp.TL_OUT}, 4'h1);
    chk("mrst_busy", {3'b0, tp.BUSY}, 4'h0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    th_fall("post_rst_start");
    ack("post_rst_a1", 4'hF);
    th_rise("post_rst_end");

    repeat (5) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations: got %0d outstanding, required 0 (next %s)",
               q.size(), q[0].nm);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/teamplayer_n.md
Name: teamplayer_n

Overview:
Parametrised multi-pad tap engine. It serves NPADS sub-pads (1-8, each 3- or 6-button or absent) over a single controller port using the TH/TR/TL nibble handshake.
It sits on the pin side of one I/O port, behind the port data/ctrl register logic, and replaces the fixed four-pad tap.
It adds programmable ack delay, a per-sequence button snapshot, variable pad count and a stall timeout.

Parameters:
NPADS, 4, number of sub-pads served (1..8).
ACK_DELAY, 4, CE ticks from a detected TR change until TL follows it (1..15).
TIMEOUT, 2048, CE ticks with TH low and no completed ack before the sequence restarts (>= 16).

Ports:
CLK  in  1  system clock; single clock domain.
RESET  in  1  asynchronous, active-high reset.
CE  in  1  clock enable; all state advances only on CLK edges with CE=1.
TH  in  1  port TH pin level driven by console (already synchronous to CLK).
TR  in  1  port TR pin level driven by console (already synchronous to CLK).
PAD_BTN  in  12*NPADS  per pad {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}, active-high pressed; pad i at [12i+11:12i].
PAD_PRESENT  in  NPADS  1 = pad i connected.
PAD_6BTN  in  NPADS  1 = pad i is 6-button (ignored if absent).
D_OUT  out  4  nibble on port data pins D3..D0.
TL_OUT  out  1  ack line to port TL pin.
BUSY  out  1  1 while a sequence is active (TH low).

Behaviour:
- Reset (async): state IDLE, D_OUT=4'h3, TL_OUT=1, BUSY=0, idx=0, ack counter=0, timeout counter=0, snapshot cleared to all released.
- TH and TR are sampled only on CE cycles. TH edge detection uses the previous CE-sampled TH (reset value 1).
- IDLE (TH=1): D_OUT=3, TL_OUT=1. A TH 1->0 sample triggers all of the following on that same CE cycle:
  - snapshot PAD_BTN/PAD_PRESENT/PAD_6BTN;
  - idx=0;
  - state ACTIVE, BUSY=1.
  - D_OUT shows nibble(0) from the next CE cycle.
- ACTIVE, ack process (level-based):
  - While TR != TL_OUT, the ack counter increments each CE.
  - When it reaches ACK_DELAY, in the same cycle: TL_OUT<=TR, idx<=idx+1 (saturating at 63), D_OUT<=nibble(idx+1), counter<=0.
  - Further TR toggles while an ack is pending do not restart the counter. If TR==TL_OUT again before expiry, the counter clears and idx is unchanged.
- Nibble map, L = 4 + NPADS + data nibbles:
  - idx 0..3: 3, F, 0, 0.
  - idx 4..4+NPADS-1: pad ID, one per pad. Absent=F, 3-button=0, 6-button=1.
  - Data nibbles follow, pads in ascending order; absent pads contribute none. Per present pad, all active-low:
    - n0 = ~{RIGHT,LEFT,DOWN,UP};
    - n1 = ~{START,A,C,B};
    - n2 (6-button only) = ~{MODE,X,Y,Z}.
    - Bit order is D3..D0.
  - idx >= L: F. Acks keep toggling TL normally.
- Outputs are driven only from the snapshot; live PAD_* changes mid-sequence have no effect.
- TH 0->1 sample in ACTIVE (at any idx, including with an ack pending): on that CE, state IDLE, D_OUT=3, TL_OUT=1, BUSY=0, idx=0, counters cleared.
- Timeout counter:
  - clears on every completed ack and on sequence start; otherwise increments each CE in ACTIVE.
  - On reaching TIMEOUT: re-snapshot, idx=0, D_OUT=nibble(0), TL_OUT<=TR, counters cleared; state stays ACTIVE.
- Simultaneous TH rise and ack expiry: TH rise wins. Simultaneous timeout and ack expiry: the ack wins, and the timeout counter clears.
- CE=0: all registers hold and outputs are stable.
- Reset mid-sequence: immediate return to reset values.

Test Plan:
1. Reset: assert RESET asynchronously mid-cycle -> D_OUT=3, TL_OUT=1, BUSY=0 immediately.
2. Full sequence, NPADS=4:
   - pad0 3-button with UP+A; pad1 6-button with Z; pad2 absent; pad3 3-button, nothing pressed.
   - Drop TH, then toggle TR 16 times waiting for TL.
   - D_OUT sequence: 3,F,0,0,0,1,F,0,E,B,F,F,E,F,F,F,F.
3. Ack timing, ACK_DELAY=4:
   - Toggle TR -> TL_OUT and D_OUT update exactly on the 4th CE after the change.
   - Same test with CE at 50% duty -> still 4 CE ticks.
   - TR toggled back after 2 ticks -> no TL change, idx unchanged.
4. Abort: raise TH at idx 7 with an ack pending -> next CE gives D_OUT=3, TL_OUT=1, BUSY=0. A new TH fall restarts at nibble 3,F,...
5. Snapshot: change pad0 to DOWN pressed at idx 5 -> idx 8 still reads E. The next sequence reads D.
6. Timeout, TIMEOUT=16: hold TH low with no TR activity for 16 CE -> D_OUT returns to 3 (idx 0), BUSY stays 1, and new PAD_* values are captured.
